// File: rtl/lgbs_uart_pkg.sv
// Shared constants and types for the LGBS UART command link.
// Used by the module-side responder and reusable on the main board.
// Optional macro: UART_CMD_STATUS_QUERY_EN. When it is defined, CMD_STATUS is
// accepted as a known command.
package lgbs_uart_pkg;

    localparam logic [7:0] CMD_ON     = 8'hEE;
    localparam logic [7:0] CMD_OFF    = 8'h55;
    localparam logic [7:0] CMD_TOGGLE = 8'hC3;
    localparam logic [7:0] CMD_STATUS = 8'hA5;
    localparam logic [7:0] NACK_BYTE  = 8'hFF;

    localparam logic [4:0] ERR_MAX = 5'd31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        REQ    = 2'd2,
        BUSY   = 2'd3
    } state_e;

    // True for every byte the responder acts on and echoes back.
    function automatic logic is_known_cmd(input logic [7:0] b);
        logic known;
        case (b)
            CMD_ON, CMD_OFF, CMD_TOGGLE: known = 1'b1;
`ifdef UART_CMD_STATUS_QUERY_EN
            CMD_STATUS:                  known = 1'b1;
`endif
            default:                     known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/cmd_link_watchdog.sv
// Link watchdog: counts enabled cycles and pulses expire when the count
// reaches CYCLES-1. The counter then returns to 0.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   enable  - count while high; counter is held at 0 while low
//   restart - clears the counter and suppresses expiry in the same cycle
//   expire  - one-cycle pulse on timeout
// CYCLES = 0 disables the watchdog.
module cmd_link_watchdog #(
    parameter int unsigned CYCLES = 192000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic expire
);

    localparam int unsigned CW      = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam bit          ENABLED = (CYCLES != 0);
    localparam logic [CW-1:0] LAST  = ENABLED ? CW'(CYCLES - 1) : '0;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        expire  = ENABLED && enable && !restart && (count_q == LAST);
        count_d = count_q + 1'b1;
        if (!ENABLED || !enable || restart || expire) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Module-side responder for the SPWM control link. It decodes bytes from
// uart_rx, drives the gate-drive enable and echoes each command via uart_tx.
// Ports:
//   clk, reset            - 24 MHz clock, asynchronous active-low reset
//   data_received/rx_done - received byte and its one-cycle strobe
//   parity_error          - qualifies rx_done; corrupt bytes are only counted
//   tx_busy               - uart_tx busy flag
//   data_to_tx/start_tx   - reply byte and transmit request
//   drive_en              - gate-drive / SPWM enable
//   wdog_tripped          - sticky; cleared by the next known command
//   overrun               - sticky; set when a clean byte is dropped
//   err_count             - saturating parity-error count
// Optional macro: UART_CMD_STATUS_QUERY_EN. When it is defined, CMD_STATUS
// returns {drive_en, wdog_tripped, overrun, err_count}.
module uart_cmd_responder #(
    parameter int unsigned WDOG_CYCLES = 192000000,
    parameter logic [7:0]  NACK_BYTE   = lgbs_uart_pkg::NACK_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_received,
    input  logic       rx_done,
    input  logic       parity_error,
    input  logic       tx_busy,
    output logic [7:0] data_to_tx,
    output logic       start_tx,
    output logic       drive_en,
    output logic       wdog_tripped,
    output logic       overrun,
    output logic [4:0] err_count
);

    import lgbs_uart_pkg::*;

    state_e     state_q, state_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       drive_q, drive_d;
    logic       tripped_q, tripped_d;
    logic       overrun_q, overrun_d;
    logic [4:0] err_q, err_d;
    logic [7:0] data_q, data_d;
    logic       start_q, start_d;
    logic       pop;
    logic       wd_restart;
    logic       wd_expire;

    cmd_link_watchdog #(
        .CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .enable (drive_q),
        .restart(wd_restart),
        .expire (wd_expire)
    );

    // Pending buffer and error bookkeeping. A pop in the same cycle frees
    // the slot, so a byte arriving during DECODE is still accepted.
    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        overrun_d  = overrun_q;
        err_d      = err_q;
        if (pop) begin
            buf_full_d = 1'b0;
        end
        if (rx_done) begin
            if (parity_error) begin
                if (err_q != ERR_MAX) begin
                    err_d = err_q + 5'd1;
                end
            end else if (!buf_full_q || pop) begin
                buf_d      = data_received;
                buf_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Command FSM with registered outputs.
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        data_d     = data_q;
        drive_d    = drive_q;
        tripped_d  = tripped_q;
        pop        = 1'b0;
        wd_restart = 1'b0;

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                pop     = 1'b1;
                state_d = REQ;
                if (is_known_cmd(buf_q)) begin
                    wd_restart = 1'b1;
                    tripped_d  = 1'b0;
                    data_d     = buf_q;
                    case (buf_q)
                        CMD_ON:     drive_d = 1'b1;
                        CMD_OFF:    drive_d = 1'b0;
                        CMD_TOGGLE: drive_d = ~drive_q;
                        default:    drive_d = drive_q;
                    endcase
`ifdef UART_CMD_STATUS_QUERY_EN
                    if (buf_q == CMD_STATUS) begin
                        data_d = {drive_q, tripped_q, overrun_q, err_q};
                    end
`endif
                end else begin
                    data_d = NACK_BYTE;
                end
            end
            REQ: begin
                // Only a busy seen while we are requesting counts as the
                // handshake; a busy left over from an earlier frame does not.
                if (start_q && tx_busy) begin
                    start_d = 1'b0;
                    state_d = BUSY;
                end else begin
                    start_d = 1'b1;
                end
            end
            BUSY: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Restart masks expiry inside the watchdog, so a command always wins.
        if (wd_expire) begin
            drive_d   = 1'b0;
            tripped_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            buf_q      <= 8'h00;
            buf_full_q <= 1'b0;
            drive_q    <= 1'b0;
            tripped_q  <= 1'b0;
            overrun_q  <= 1'b0;
            err_q      <= 5'd0;
            data_q     <= 8'h00;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            drive_q    <= drive_d;
            tripped_q  <= tripped_d;
            overrun_q  <= overrun_d;
            err_q      <= err_d;
            data_q     <= data_d;
            start_q    <= start_d;
        end
    end

    assign data_to_tx   = data_q;
    assign start_tx     = start_q;
    assign drive_en     = drive_q;
    assign wdog_tripped = tripped_q;
    assign overrun      = overrun_q;
    assign err_count    = err_q;

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Module-side counterpart of the main board's command sender. Consumes bytes from the local uart_rx (data_received/rx_done/parity_error) and decodes the SPWM control commands. Drives the module's gate-drive enable and echoes each accepted command back through the local uart_tx (data_to_tx/start_tx/tx_busy).
- Includes a link watchdog that forces the output off when the main board goes silent.

Parameters:
- WDOG_CYCLES, 192000000, clk cycles without a valid command before forced turn-off (8 s at 24 MHz); 0 disables the watchdog.
- NACK_BYTE, 8'hFF, reply sent for an unrecognised command byte.

Ports:
- clk  input  1  system clock, 24 MHz from HFOSC.
- reset  input  1  asynchronous, active-low reset.
- data_received  input  8  byte from uart_rx, valid when rx_done=1.
- rx_done  input  1  one-cycle strobe, byte received.
- parity_error  input  1  qualifies rx_done; 1 = byte corrupt.
- tx_busy  input  1  uart_tx busy flag.
- data_to_tx  output  8  reply byte; stable while start_tx=1 or tx_busy=1.
- start_tx  output  1  transmit request to uart_tx.
- drive_en  output  1  gate-drive / SPWM enable for this module.
- wdog_tripped  output  1  sticky; set on watchdog expiry, cleared by the next valid command.
- overrun  output  1  sticky; set when a byte is dropped, cleared only by reset.
- err_count  output  5  parity-error counter; saturates at 31.

Behaviour:
- Reset (asserted low, async) forces: drive_en=0, start_tx=0, data_to_tx=8'h00, wdog_tripped=0, overrun=0, err_count=0, watchdog counter=0, pending buffer empty, state=IDLE.
- Command codes (shared constants): CMD_ON=8'hEE sets drive_en=1; CMD_OFF=8'h55 sets drive_en=0; CMD_TOGGLE=8'hC3 inverts drive_en.
- Byte with rx_done=1 and parity_error=1: discarded, no reply, err_count+1 (saturating at 31).
- Clean bytes enter a 1-deep pending buffer.
  - Buffer empty: the byte is captured.
  - Buffer full: the byte is dropped and overrun is set.
- FSM states:
  - IDLE: if the buffer is full, go to DECODE.
  - DECODE (1 cycle):
    - Known command: apply its effect to drive_en, set data_to_tx=byte, clear wdog_tripped, restart the watchdog.
    - Unknown byte: set data_to_tx=NACK_BYTE; drive_en and watchdog unchanged.
    - Either case: pop the buffer, go to REQ.
  - REQ: start_tx=1; on tx_busy=1 go to BUSY with start_tx=0 (start_tx held until busy is seen).
  - BUSY: wait for tx_busy=0, then go to IDLE.
- Latency:
  - drive_en updates 2 cycles after the rx_done edge (capture, then DECODE).
  - start_tx rises 3 cycles after the rx_done edge.
- rx_done arriving in the same cycle that DECODE pops the buffer: the new byte is accepted, with no overrun.
- Watchdog:
  - Counts every cycle while drive_en=1; holds at 0 while drive_en=0.
  - On reaching WDOG_CYCLES-1: drive_en=0, wdog_tripped=1, counter=0. No UART reply is generated.
  - Watchdog expiry in the same cycle as a DECODE of a valid command: the command wins.
- Reset asserted mid-transmission: start_tx drops immediately; the remainder of the frame is owned by uart_tx.

Optional Feature:
- Macro: UART_CMD_STATUS_QUERY_EN.
- Defined: CMD_STATUS=8'hA5 is decoded as known.
  - Reply: {drive_en, wdog_tripped, overrun, err_count}.
  - No change to drive_en; watchdog restarts.
- Undefined: 8'hA5 is unknown and answered with NACK_BYTE.

Decomposition:
- Package lgbs_uart_pkg holds:
  - Command constants CMD_ON, CMD_OFF, CMD_TOGGLE, CMD_STATUS, NACK_BYTE.
  - FSM state encoding (IDLE, DECODE, REQ, BUSY, 2 bits).
- One sub-module: cmd_link_watchdog (counter, expiry pulse, restart input), reused on the main board for reply supervision.

Test Plan:
- Reset low then high; rx 8'hEE clean: drive_en=1 at +2 cycles, start_tx=1 with data_to_tx=8'hEE; bench raises tx_busy: start_tx=0; tx_busy low: FSM returns to IDLE.
- Sequence 8'hC3, 8'hC3, 8'h55 from drive_en=1: drive_en goes 0, 1, 0; three echoes 8'hC3, 8'hC3, 8'h55.
- rx 8'h12: reply 8'hFF, drive_en unchanged. rx 8'hEE with parity_error=1: no start_tx, err_count=1. 40 parity errors: err_count=31.
- WDOG_CYCLES=1000, 8'hEE then silence: drive_en=0 and wdog_tripped=1 exactly 1000 cycles after the counter starts; the next 8'hEE clears wdog_tripped.
- Hold tx_busy=1 and send three clean bytes: first is in DECODE/REQ, second is buffered, third is dropped and overrun=1. Release busy: exactly two replies.
- With UART_CMD_STATUS_QUERY_EN defined, state drive_en=1 and err_count=3, rx 8'hA5: reply 8'b1000_0011. Without the macro: reply 8'hFF.
